// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the backing-memory port sequencer.
//   t_arb_state : sequencer states (IDLE -> BUSY -> RESP -> IDLE)
//   t_port      : requester identity (instruction side / data side)
//   t_mem_req   : request fields latched at grant and driven onto the memory port
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } t_arb_state;

  typedef enum logic {
    PORT_I,
    PORT_D
  } t_port;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } t_mem_req;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every request/response/memory signal around the arbiter.
//   slave  : the arbiter's view (takes requests and memory responses,
//            drives acks, read data, the memory command and stall)
//   master : the environment's view (requesters plus backing memory)
interface mem_port_arbiter_if;

  // instruction side
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;

  // data side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  // backing memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // pipeline freeze
  logic        stall;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ack, mem_rdata,
    output i_ack, i_rdata, i_err,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ack, mem_rdata,
    input  i_ack, i_rdata, i_err,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall
  );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Arb_RoundRobin2: combinational two-way picker.
//   i_req, d_req : pending requests
//   last_grant   : side granted by the previous completed transaction
//   valid        : at least one request pending
//   winner       : chosen side; on a tie, the side not granted last
// Kept as its own block so a different policy (e.g. fixed priority) can be
// dropped in without touching the sequencer.
module Arb_RoundRobin2
  import arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
  input  t_port last_grant,
  output logic  valid,
  output t_port winner
);

  always_comb begin
    valid  = i_req | d_req;
    winner = PORT_I;
    if (i_req && d_req) begin
      winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequencer for the single backing-memory port shared by
// the instruction-side and data-side requesters.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_port_arbiter_if.slave
//           i_* / d_* request and response handshakes,
//           mem_* memory command/response, stall to the pipeline.
// One transaction at a time: grant in IDLE, hold the latched command on the
// memory port during BUSY until mem_ack or the watchdog fires, then pulse the
// granted side's ack in RESP.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  t_arb_state       state_reg,      state_next;
  logic [CNT_W-1:0] cnt_reg,        cnt_next;
  t_mem_req         req_reg,        req_next;
  t_port            gnt_reg,        gnt_next;
  t_port            last_grant_reg, last_grant_next;
  logic [31:0]      rdata_reg,      rdata_next;
  logic             err_reg,        err_next;

  logic  pick_valid;
  t_port pick_winner;
  logic  resp_i;
  logic  resp_d;

  Arb_RoundRobin2 u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Reset starts with last_grant = I so that D wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      req_reg        <= '0;
      gnt_reg        <= PORT_I;
      last_grant_reg <= PORT_I;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      req_reg        <= req_next;
      gnt_reg        <= gnt_next;
      last_grant_reg <= last_grant_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    req_next        = req_reg;
    gnt_next        = gnt_reg;
    last_grant_next = last_grant_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next = pick_winner;
          if (pick_winner == PORT_D) begin
            req_next.we    = bus.d_we;
            req_next.addr  = bus.d_addr;
            req_next.wdata = bus.d_wdata;
          end else begin
            // instruction fetches are always reads
            req_next.we    = 1'b0;
            req_next.addr  = bus.i_addr;
            req_next.wdata = '0;
          end
          cnt_next   = '0;
          state_next = BUSY;
        end
      end

      BUSY: begin
        // a completion in the watchdog's final cycle still counts as success
        if (bus.mem_ack) begin
          rdata_next = bus.mem_rdata;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == WAIT_LAST) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RESP: begin
        last_grant_next = gnt_reg;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign resp_i = (state_reg == RESP) && (gnt_reg == PORT_I);
  assign resp_d = (state_reg == RESP) && (gnt_reg == PORT_D);

  assign bus.mem_req   = (state_reg == BUSY);
  assign bus.mem_we    = req_reg.we;
  assign bus.mem_addr  = req_reg.addr;
  assign bus.mem_wdata = req_reg.wdata;

  // response fields are only shown to the side being acknowledged
  assign bus.i_ack   = resp_i;
  assign bus.i_rdata = resp_i ? rdata_reg : '0;
  assign bus.i_err   = resp_i & err_reg;
  assign bus.d_ack   = resp_d;
  assign bus.d_rdata = resp_d ? rdata_reg : '0;
  assign bus.d_err   = resp_d & err_reg;

  assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for the single backing-memory port, shared between the instruction-side requester (fetch / I-cache miss) and the data-side requester (memory stage / D-cache miss). It grants one requester at a time and holds the granted request on the memory port until the memory acknowledges or a watchdog expires. It returns the response to the granted requester and drives the pipeline-wide `stall` consumed by Stage_Execute and the other stages.

## Interface
Parameters:
- `MAX_WAIT`, default 16: maximum number of BUSY cycles without `mem_ack` before the transaction is aborted with an error.
- `CNT_W`, default 5: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `i_req`  in  1  instruction-side request; held high until `i_ack`.
- `i_addr`  in  32  instruction word address.
- `i_ack`  out  1  one-cycle pulse; `i_rdata` and `i_err` are valid in this cycle.
- `i_rdata`  out  32  read data.
- `i_err`  out  1  watchdog abort flag.
- `d_req`  in  1  data-side request; held high until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  write data.
- `d_ack`, `d_rdata`, `d_err`  out  1/32/1  same semantics as the I-side outputs.
- `mem_req`  out  1  held high for the whole BUSY state.
- `mem_we`  out  1  latched write flag; always 0 for I-side grants.
- `mem_addr`, `mem_wdata`  out  32  latched at grant; stable during BUSY.
- `mem_ack`  in  1  one-cycle completion pulse from memory.
- `mem_rdata`  in  32  valid when `mem_ack` is high.
- `stall`  out  1  pipeline freeze.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is pending: select the winner, latch its we/addr/wdata and identity, clear the wait counter, and go to BUSY.
  - Single requester: that requester wins.
  - Both requesting: winner is the side that was not granted last (round-robin on `last_grant`).
- BUSY: `mem_req` = 1. The counter increments each cycle.
  - `mem_ack` = 1: latch `mem_rdata`, err = 0, go to RESP.
  - Else, counter == MAX_WAIT-1: rdata = 0, err = 1, go to RESP.
  - `mem_ack` has priority over the watchdog in the same cycle.
- RESP:
  - Pulse the ack of the granted side; present the registered rdata/err on that side only.
  - Update `last_grant`; go to IDLE.
- `stall` = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- Requester dropping req during BUSY: the transaction still completes and the ack is pulsed (harmless). The requester must not alter addr/wdata before its ack; values are latched regardless.
- `mem_ack` arriving in IDLE or RESP (late response after abort) is ignored.
- `mem_rdata` on writes is latched as-is; requesters ignore it.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, `last_grant` = I, so D wins the first tie.
  - All outputs are 0: ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata.
  - `stall` follows its inputs.
- Reset in BUSY: `mem_req` drops immediately, the transaction is discarded, and no ack is issued. The requester re-requests after reset.
- Request latency: request seen at edge N puts `mem_req` high from cycle N+1.
  - `mem_ack` in cycle N+k gives the requester ack in cycle N+k+1.
  - Back-to-back minimum is 3 cycles per transaction with `mem_ack` in the first BUSY cycle.
- A requester whose ack is in cycle T may re-request in cycle T+1. It is considered at edge T+1, since RESP → IDLE occurs at edge T.
- Watchdog: with no `mem_ack`, BUSY lasts exactly MAX_WAIT cycles; `*_err` is pulsed in the following cycle.

## Structure
- Shared package `arb_pkg`:
  - `t_arb_state` enum {IDLE, BUSY, RESP}.
  - `t_port` enum {PORT_I, PORT_D}.
  - `t_mem_req` struct {we, addr, wdata}.
- One sub-module, `Arb_RoundRobin2`: combinational two-way picker taking (i_req, d_req, last_grant) and returning {valid, winner}. It is kept separate so the policy can be swapped for fixed-priority cache experiments.

## Test plan
- Single D read:
  - Stimulus: d_req with addr 0x100; mem_ack with rdata 0xDEADBEEF in the 2nd BUSY cycle.
  - Response: mem_req high 2 cycles, then d_ack one cycle with d_rdata 0xDEADBEEF and d_err 0; `stall` is 1 until the ack cycle and 0 after.
- Simultaneous i_req and d_req from reset:
  - Response: D granted first; I granted immediately after the D RESP cycle; `mem_we` = 0 on the I grant.
- Both sides requesting continuously for 4 transactions:
  - Response: grants alternate D, I, D, I; `mem_addr` matches the granted side each time.
- Watchdog:
  - Stimulus: MAX_WAIT = 16, no mem_ack.
  - Response: mem_req high exactly 16 cycles, then i_ack with i_err 1 and i_rdata 0.
  - Follow-up: a late mem_ack in the next cycle produces no ack.
- D write:
  - Stimulus: d_we 1, addr 0x40, wdata 0x12345678; d_addr changed during BUSY.
  - Response: mem_we 1, mem_addr 0x40 and mem_wdata 0x12345678 stable through BUSY.
- Reset in BUSY:
  - Stimulus: reset asserted in the 3rd BUSY cycle.
  - Response: mem_req is 0 without a clock edge; no ack after release; next tie goes to D.
